reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Arbitrates write access to the register file's single write port among several requesters (ALU writeback, load unit, link/PC writeback).
- Converts the granted request into a one-hot per-register load enable plus a shared 32-bit data bus, driving the `load_enable`/`in` pins of the 32-bit registers.
- One registered output stage; sits between the execute/memory stages and the register file.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = ALU, 1 = load unit, 2 = link.
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 4, register address width.
- NUM_REGS, 16, number of registers; always equals 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed destination addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  grant; a request is accepted when req_valid[i] and req_ready[i] are both high at a rising edge.
- stall  in  1  high blocks all new grants.
- reg_load_enable  out  NUM_REGS  one-hot register load enable.
- reg_in  out  DATA_WIDTH  write data to all registers.
- busy  out  1  output stage holds a write.
- conflict_count  out  8  saturating count of contention cycles.

Behaviour:
- Reset (clr high at an edge): reg_load_enable=0, reg_in=0, busy=0, conflict_count=0, priority pointer=0. Reset has priority over every other event.
- Reset mid-operation: an in-flight write is dropped and no load enable is issued.
- req_ready is combinational from req_valid, stall and the priority pointer.
  - At most one bit is high.
  - req_ready is all-zero when stall=1 or no req_valid bit is set.
  - req_ready[i] never rises without req_valid[i].
- Output stage FSM:
  - States: IDLE (busy=0) and WRITE (busy=1).
  - IDLE -> WRITE on an accept.
  - WRITE -> WRITE on a back-to-back accept.
  - WRITE -> IDLE when there is no accept.
- Latency:
  - Accept at edge N.
  - During cycle N..N+1: reg_in = accepted data and reg_load_enable has exactly bit [addr] set.
  - Target register updates at edge N+1.
- Throughput: one write per cycle; no bubbles between back-to-back accepts.
- In WRITE, reg_load_enable stays one-hot. In IDLE, reg_load_enable=0 and reg_in holds its last value.
- stall only blocks new grants; a write already in the output stage completes.
- The arbiter does not coalesce requests. Same-address requests on consecutive cycles produce two writes; the later one wins.
- conflict_count increments by 1 on each non-stalled cycle where two or more req_valid bits are high. It saturates at 8'hFF. Stalled cycles do not count.
- The priority pointer is touched only by the optional feature; without it, the pointer stays 0.

Optional Feature:
- Macro: WB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration. The search starts at index (ptr) and wraps modulo NUM_REQ.
  - On each accept, ptr <- (granted index + 1) mod NUM_REQ. The pointer is unchanged when there is no accept.
- Undefined:
  - Fixed priority; the lowest index wins (ALU > load > link).
  - Pointer logic is not synthesized.

Test Plan:
- Reset, then req_valid=3'b001, addr0=4'h5, data0=32'h0000000A -> req_ready=3'b001 at edge N; reg_load_enable=16'h0020 and reg_in=32'h0000000A for exactly one cycle; busy returns to 0.
- req_valid=3'b111 held 3 cycles, addrs 1/2/3, data A/B/C:
  - Fixed priority: grants 001,001,001 and conflict_count=3.
  - WB_ROUND_ROBIN_EN: grants 001,010,100; reg_load_enable 0002,0004,0008.
- stall=1 with req_valid=3'b010 for 2 cycles -> req_ready=0, reg_load_enable=0, conflict_count unchanged; on stall=0 the write issues next cycle.
- Back-to-back accepts from requester 1 with addr 7 on 2 cycles, data 32'h0000000B then 32'h0000000C -> busy stays 1; reg_load_enable=16'h0080 both cycles; final register value 32'h0000000C.
- Accept at edge N with clr=1 at edge N+1 -> reg_load_enable=0 after edge N+1, busy=0, conflict_count=0.
- 300 cycles with req_valid=3'b011 -> conflict_count saturates at 8'hFF and does not wrap.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: grants one requester per cycle and drives one-hot load enables plus shared data.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module reg_write_arbiter_lane #(
    parameter int ADDR_WIDTH = 4,
    parameter int IDX        = 0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  en,
    output logic                  hit
);
    assign hit = en && (addr == ADDR_WIDTH'(IDX));
endmodule

module reg_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          stall,
    output logic [NUM_REGS-1:0]           reg_load_enable,
    output logic [DATA_WIDTH-1:0]         reg_in,
    output logic                          busy,
    output logic [7:0]                    conflict_count
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, WRITE} state_t;
    state_t state_q, state_d;

    logic [PTR_W-1:0]      ptr;
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REGS-1:0]   hit;
    logic                  multi;

    // Search starts at ptr and wraps; with ptr tied to 0 this is plain fixed priority.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        if (!stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (grant == '0 && req_valid[idx]) grant[idx] = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef WB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr_q, ptr_nxt;

    always_comb begin
        ptr_nxt = ptr_q;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) ptr_nxt = PTR_W'((i + 1) % NUM_REQ);
    end

    always_ff @(posedge clk) begin
        if (clr) ptr_q <= '0;
        else     ptr_q <= ptr_nxt;
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    genvar r;
    generate
        for (r = 0; r < NUM_REGS; r++) begin : g_lane
            reg_write_arbiter_lane #(.ADDR_WIDTH(ADDR_WIDTH), .IDX(r)) u_lane (
                .addr (sel_addr),
                .en   (accept),
                .hit  (hit[r])
            );
        end
    endgenerate

    always_comb begin
        state_d = IDLE;
        if (accept) state_d = WRITE;
    end

    always_ff @(posedge clk) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign busy = (state_q == WRITE);

    // reg_in keeps its last value while idle; only the enables drop.
    always_ff @(posedge clk) begin
        if (clr) begin
            reg_load_enable <= '0;
            reg_in          <= '0;
        end else begin
            reg_load_enable <= hit;
            if (accept) reg_in <= sel_data;
        end
    end

    assign multi = !stall && ($countones(req_valid) > 1);

    always_ff @(posedge clk) begin
        if (clr)                                  conflict_count <= 8'h00;
        else if (multi && conflict_count != 8'hFF) conflict_count <= conflict_count + 8'h01;
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed-vector bench for reg_write_arbiter with a small register-file model on the load enables.
module tb_reg_write_arbiter;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [11:0] req_addr = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_ready;
    logic        stall = 1'b0;
    logic [15:0] reg_load_enable;
    logic [31:0] reg_in;
    logic        busy;
    logic [7:0]  conflict_count;
    logic [31:0] rf [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_write_arbiter dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .stall(stall),
        .reg_load_enable(reg_load_enable), .reg_in(reg_in), .busy(busy),
        .conflict_count(conflict_count)
    );

    always @(posedge clk)
        for (int i = 0; i < 16; i++) if (reg_load_enable[i]) rf[i] <= reg_in;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        clr = 1'b1; req_valid = '0; stall = 1'b0;
        tick;
        clr = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (reg_load_enable !== 16'h0) begin errors++; $display("FAIL reset_le got %h exp 0000", reg_load_enable); end
        checks++; if (reg_in !== 32'h0) begin errors++; $display("FAIL reset_in got %h exp 00000000", reg_in); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (conflict_count !== 8'h0) begin errors++; $display("FAIL reset_cc got %h exp 00", conflict_count); end
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", req_ready); end
    endtask

    task automatic test_single;
        do_reset;
        req_valid = 3'b001; req_addr = {4'h0, 4'h0, 4'h5}; req_data = {32'h0, 32'h0, 32'h0000000A};
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got %b exp 001", req_ready); end
        tick;
        req_valid = '0;
        checks++; if (reg_load_enable !== 16'h0020) begin errors++; $display("FAIL single_le got %h exp 0020", reg_load_enable); end
        checks++; if (reg_in !== 32'h0000000A) begin errors++; $display("FAIL single_in got %h exp 0000000a", reg_in); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        tick;
        checks++; if (reg_load_enable !== 16'h0) begin errors++; $display("FAIL single_le_off got %h exp 0000", reg_load_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
        checks++; if (reg_in !== 32'h0000000A) begin errors++; $display("FAIL single_hold got %h exp 0000000a", reg_in); end
    endtask

    task automatic test_contention;
        logic [2:0]  exp_rdy [3];
        logic [15:0] exp_le  [3];
`ifdef WB_ROUND_ROBIN_EN
        exp_rdy = '{3'b001, 3'b010, 3'b100};
        exp_le  = '{16'h0002, 16'h0004, 16'h0008};
`else
        exp_rdy = '{3'b001, 3'b001, 3'b001};
        exp_le  = '{16'h0002, 16'h0002, 16'h0002};
`endif
        do_reset;
        req_valid = 3'b111; req_addr = {4'h3, 4'h2, 4'h1};
        req_data = {32'h0000000C, 32'h0000000B, 32'h0000000A};
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL cont_ready%0d got %b exp %b", c, req_ready, exp_rdy[c]); end
            tick;
            checks++; if (reg_load_enable !== exp_le[c]) begin errors++; $display("FAIL cont_le%0d got %h exp %h", c, reg_load_enable, exp_le[c]); end
        end
        req_valid = '0;
        tick;
        checks++; if (conflict_count !== 8'd3) begin errors++; $display("FAIL cont_cc got %0d exp 3", conflict_count); end
    endtask

    task automatic test_stall;
        do_reset;
        stall = 1'b1; req_valid = 3'b010; req_addr = {4'h0, 4'h6, 4'h0}; req_data = {32'h0, 32'h00000066, 32'h0};
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready%0d got %b exp 000", c, req_ready); end
            tick;
            checks++; if (reg_load_enable !== 16'h0) begin errors++; $display("FAIL stall_le%0d got %h exp 0000", c, reg_load_enable); end
        end
        checks++; if (conflict_count !== 8'h0) begin errors++; $display("FAIL stall_cc got %h exp 00", conflict_count); end
        stall = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL unstall_ready got %b exp 010", req_ready); end
        tick;
        stall = 1'b1; req_valid = '0;
        checks++; if (reg_load_enable !== 16'h0040) begin errors++; $display("FAIL unstall_le got %h exp 0040", reg_load_enable); end
        checks++; if (reg_in !== 32'h00000066) begin errors++; $display("FAIL unstall_in got %h exp 00000066", reg_in); end
        tick;
        stall = 1'b0;
        checks++; if (rf[6] !== 32'h00000066) begin errors++; $display("FAIL unstall_rf got %h exp 00000066", rf[6]); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        req_valid = 3'b010; req_addr = {4'h0, 4'h7, 4'h0}; req_data = {32'h0, 32'h0000000B, 32'h0};
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL b2b_ready got %b exp 010", req_ready); end
        tick;
        req_data = {32'h0, 32'h0000000C, 32'h0};
        checks++; if (reg_load_enable !== 16'h0080) begin errors++; $display("FAIL b2b_le0 got %h exp 0080", reg_load_enable); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy0 got %b exp 1", busy); end
        tick;
        req_valid = '0;
        checks++; if (reg_load_enable !== 16'h0080) begin errors++; $display("FAIL b2b_le1 got %h exp 0080", reg_load_enable); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy1 got %b exp 1", busy); end
        checks++; if (reg_in !== 32'h0000000C) begin errors++; $display("FAIL b2b_in got %h exp 0000000c", reg_in); end
        tick;
        checks++; if (rf[7] !== 32'h0000000C) begin errors++; $display("FAIL b2b_rf got %h exp 0000000c", rf[7]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        req_valid = 3'b011; req_addr = {4'h0, 4'h9, 4'h4}; req_data = {32'h0, 32'h22, 32'h11};
        tick;
        checks++; if (reg_load_enable !== 16'h0010) begin errors++; $display("FAIL mid_le got %h exp 0010", reg_load_enable); end
        checks++; if (conflict_count !== 8'd1) begin errors++; $display("FAIL mid_cc got %0d exp 1", conflict_count); end
        clr = 1'b1;
        tick;
        clr = 1'b0; req_valid = '0;
        checks++; if (reg_load_enable !== 16'h0) begin errors++; $display("FAIL mid_clr_le got %h exp 0000", reg_load_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_clr_busy got %b exp 0", busy); end
        checks++; if (conflict_count !== 8'h0) begin errors++; $display("FAIL mid_clr_cc got %h exp 00", conflict_count); end
    endtask

    task automatic test_saturate;
        do_reset;
        req_valid = 3'b011; req_addr = '0; req_data = '0;
        repeat (254) tick;
        checks++; if (conflict_count !== 8'hFE) begin errors++; $display("FAIL sat_254 got %h exp fe", conflict_count); end
        tick;
        checks++; if (conflict_count !== 8'hFF) begin errors++; $display("FAIL sat_255 got %h exp ff", conflict_count); end
        repeat (45) tick;
        checks++; if (conflict_count !== 8'hFF) begin errors++; $display("FAIL sat_300 got %h exp ff", conflict_count); end
        req_valid = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        test_saturate;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
